conv1_out_serializer: RTL
=========================

// Module: conv1_out_serializer
// PURPOSE
//   Drains one conv1 result frame (NUM_CH parallel fp32 channel words) into a
//   one-word-per-cycle valid/ready stream tagged with channel index and last flag.
//   Sits between the conv1 layer's parallel output bus and the next stage
//   (pooling / off-chip writer). Optional ReLU clamp applied per word.
// PARAMETERS
//   NUM_CH   32  channel words per frame (>=2)
//   DATA_W   32  word width; IEEE-754 single, sign at bit DATA_W-1
//   CH_W     5   channel index width, = clog2(NUM_CH)
//   RELU_EN  1   1: words with sign bit set output as 0; 0: pass through
// PORTS
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous reset, active-high
//   in_valid   in   1              frame on in_data is valid
//   in_ready   out  1              frame can be accepted this cycle
//   in_data    in   NUM_CH*DATA_W  flattened frame; ch k = in_data[k*DATA_W +: DATA_W]
//   out_valid  out  1              out_data/out_ch/out_last valid
//   out_ready  in   1              downstream accepts this cycle
//   out_data   out  DATA_W         channel word (after optional ReLU)
//   out_ch     out  CH_W           channel index of out_data
//   out_last   out  1              high with ch NUM_CH-1 only
//   frame_cnt  out  16             completed frames, wraps 16'hFFFF -> 0
// BEHAVIOUR
//   - Reset (rst high at edge): state IDLE, out_valid=0, out_data=0, out_ch=0,
//     out_last=0, frame_cnt=0, frame buffer cleared. in_ready=0 while rst high.
//   - Transfer = valid & ready at rising edge, on both interfaces.
//   - in_ready (comb) = !rst & (state==IDLE | (out_valid & out_ready & out_last)).
//   - IDLE: in transfer at edge N -> latch whole in_data into buffer, ch=0,
//     go SEND; out_valid=1 with ch 0 from cycle N+1 (latency 1).
//   - SEND: out_data = f(buffer[ch]), out_ch=ch, out_last=(ch==NUM_CH-1).
//     out transfer and ch<NUM_CH-1 -> ch+1. out_ready low -> all out_* held.
//   - Last beat transfer: frame_cnt+1; if in transfer same edge -> latch new
//     frame, ch=0, stay SEND (no bubble); else -> IDLE, out_valid=0.
//   - in_valid during SEND before last-beat transfer: ignored (in_ready=0);
//     upstream must hold frame stable until its transfer.
//   - ReLU: RELU_EN=1 and word[DATA_W-1]=1 -> 0 (covers -0, negative, and
//     sign-set NaN/inf); otherwise word unchanged. No other arithmetic.
//   - ch never exceeds NUM_CH-1; no wrap within a frame.
//   - Reset mid-frame: remaining words discarded, frame_cnt not incremented,
//     outputs at reset values next cycle; next frame restarts at ch 0.
//   - Sustained throughput 1 word/cycle with out_ready held high.
// TESTING
//   1 Reset 2 cycles -> out_valid=0,out_data=0,out_ch=0,out_last=0,frame_cnt=0;
//     in_ready=0 during rst, 1 first cycle after.
//   2 Frame word k=32'h4200_0000+k, out_ready=1, accept at edge N -> beats at
//     N+1..N+32, out_ch 0..31 in order, out_last only on ch 31, frame_cnt=1.
//   3 RELU_EN=1: ch5=32'hC080_0000, ch6=32'h8000_0000, ch7=32'h3F80_0000 ->
//     out 0, 0, 32'h3F80_0000; RELU_EN=0 -> all three unchanged.
//   4 out_ready pattern 1,0,0,1,0,1... -> outputs stable while stalled, each
//     ch exactly once; in_valid with new frame mid-SEND -> in_ready=0, ignored.
//   5 in_valid held with frame B at A's last beat -> B ch0 next cycle, 64 beats
//     in 64 consecutive cycles, frame_cnt=2.
//   6 rst pulse while out_ch=10 -> out_valid=0 next cycle, frame_cnt unchanged
//     (0); following frame starts ch 0; frame_cnt preset path wraps FFFF->0.

Source files
------------

// File: rtl/conv1_out_serializer.sv
// Purpose: drains one conv1 frame (NUM_CH parallel words) into a one-word-per-cycle
//          valid/ready stream tagged with channel index and last flag, optional ReLU.
// Latency: first word one cycle after frame accept; back-to-back frames with no bubble.
// Backpressure: out_ready low holds all out_* stable; new frame accepted only when idle
//               or on the same edge as the last-beat transfer.
module conv1_out_serializer #(
  parameter int NUM_CH  = 32,
  parameter int DATA_W  = 32,
  parameter int CH_W    = 5,
  parameter int RELU_EN = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_last,
  output logic [15:0]              frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t                     state_q, state_d;
  logic [NUM_CH*DATA_W-1:0]   buf_q, buf_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic                       out_valid_q, out_valid_d;
  logic [DATA_W-1:0]          out_data_q, out_data_d;
  logic                       out_last_q, out_last_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;

  logic                       in_fire;
  logic                       out_fire;
  logic                       last_fire;
  logic [CH_W-1:0]            ch_inc;

  // Clamp sign-set words to zero when ReLU is enabled; this also zeroes -0,
  // negative infinity and sign-set NaNs, which is what the next stage expects.
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] w);
    if ((RELU_EN != 0) && w[DATA_W-1]) begin
      return '0;
    end
    return w;
  endfunction

  assign out_fire  = out_valid_q & out_ready;
  assign last_fire = out_fire & out_last_q;
  assign in_ready  = !rst & ((state_q == IDLE) | last_fire);
  assign in_fire   = in_valid & in_ready;
  assign ch_inc    = ch_q + CH_W'(1);

  // Next-state: frame capture, channel advance, and frame completion counting.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    ch_d        = ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_cnt_d = frame_cnt_q;

    if (in_fire) begin
      // New frame (from IDLE or chained on the last beat): present ch 0 next cycle.
      buf_d       = in_data;
      ch_d        = '0;
      state_d     = SEND;
      out_valid_d = 1'b1;
      out_data_d  = relu(in_data[DATA_W-1:0]);
      out_last_d  = 1'b0;
    end else if (out_fire) begin
      if (out_last_q) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end else begin
        ch_d       = ch_inc;
        out_data_d = relu(buf_q[int'(ch_inc)*DATA_W +: DATA_W]);
        out_last_d = (ch_inc == LAST_CH);
      end
    end

    if (last_fire) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // State and output registers; synchronous reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = ch_q;
  assign out_last  = out_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule
